// File: rtl/mcb_pkg.sv
// mcb_pkg
// Shared definitions for the MCB user-port stand-in: command encodings,
// FIFO depths and entry widths, the command FIFO entry layout and the
// responder FSM state encoding.
// Optional build macro: MCB_RESP_REFRESH_EN adds the REFRESH stall state.
package mcb_pkg;

  localparam logic [2:0] INSTR_WRITE    = 3'b000;
  localparam logic [2:0] INSTR_READ     = 3'b001;
  localparam logic [2:0] INSTR_WRITE_AP = 3'b010;
  localparam logic [2:0] INSTR_READ_AP  = 3'b011;

  localparam int CMD_FIFO_DEPTH  = 4;
  localparam int DATA_FIFO_DEPTH = 64;
  localparam int REFRESH_STALL   = 8;

  localparam int CMD_ENTRY_W = 45;
  localparam int WR_ENTRY_W  = 72;
  localparam int RD_ENTRY_W  = 64;

  // Command FIFO entry; the reserved field pads the entry to the MCB
  // command word width and is always written as zero.
  typedef struct packed {
    logic [5:0]  rsvd;
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] byteAddr;
  } cmdEntry_t;

  typedef enum logic [2:0] {
    ST_CALIB,
    ST_IDLE,
    ST_WR_WAIT,
    ST_WRITE,
    ST_RD_WAIT,
    ST_READ
`ifdef MCB_RESP_REFRESH_EN
    , ST_REFRESH
`endif
  } state_e;

  function automatic logic isWriteCmd(input logic [2:0] instr);
    return (instr == INSTR_WRITE) || (instr == INSTR_WRITE_AP);
  endfunction

  function automatic logic isReadCmd(input logic [2:0] instr);
    return (instr == INSTR_READ) || (instr == INSTR_READ_AP);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   push_i, data_i        write side; a push while full is dropped
//   pop_i, data_o         read side; data_o is the head entry (0 when empty)
//   count_o               occupancy 0..DEPTH
//   full_o, empty_o       status decoded from the registered count
//   overflow_o            push attempted while full (this cycle)
//   underflow_o           pop attempted while empty (this cycle)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign doPush      = push_i & ~full_o;
  assign doPop       = pop_i & ~empty_o;
  assign overflow_o  = push_i & full_o;
  assign underflow_o = pop_i & empty_o;
  assign count_o     = count_q;
  // Masking the head keeps the output at zero after reset and when drained.
  assign data_o      = empty_o ? '0 : mem[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (doPush) mem[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mcb_port_responder.sv
// mcb_port_responder
// Block-RAM backed stand-in for one 64-bit MCB user port. Accepts the
// cmd / write-data / read-data FIFO protocol of the DDR initiators.
// Ports:
//   clk_i, reset_n_i                 clock, asynchronous active-low reset
//   calib_done_o                     high once emulated calibration ends
//   cmd_en_i, cmd_instr_i, cmd_bl_i,
//   cmd_byte_addr_i                  command push (bl = words - 1)
//   cmd_full_o, cmd_empty_o          command FIFO status (depth 4)
//   wr_en_i, wr_data_i, wr_mask_i    write-data push (mask 1 = keep byte)
//   wr_full_o, wr_empty_o, wr_count_o  write FIFO status (depth 64)
//   rd_en_i, rd_data_o               read-data pop, FWFT head
//   rd_full_o, rd_empty_o, rd_count_o  read FIFO status (depth 64)
//   error_o                          sticky [0] cmd overflow,
//                                    [1] wr overflow, [2] rd underflow
// Optional build macro: MCB_RESP_REFRESH_EN injects periodic 8-cycle
// refresh stalls between bursts.
module mcb_port_responder
  import mcb_pkg::*;
#(
  parameter int AW             = 10,
  parameter int CALIB_CYCLES   = 16,
  parameter int REFRESH_PERIOD = 780
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  output logic        calib_done_o,
  input  logic        cmd_en_i,
  input  logic [2:0]  cmd_instr_i,
  input  logic [5:0]  cmd_bl_i,
  input  logic [29:0] cmd_byte_addr_i,
  output logic        cmd_full_o,
  output logic        cmd_empty_o,
  input  logic        wr_en_i,
  input  logic [63:0] wr_data_i,
  input  logic [7:0]  wr_mask_i,
  output logic        wr_full_o,
  output logic        wr_empty_o,
  output logic [6:0]  wr_count_o,
  input  logic        rd_en_i,
  output logic [63:0] rd_data_o,
  output logic        rd_full_o,
  output logic        rd_empty_o,
  output logic [6:0]  rd_count_o,
  output logic [2:0]  error_o
);

  localparam logic [15:0] CALIB_LAST = 16'(CALIB_CYCLES - 1);

  state_e          state_q, state_d;
  logic [15:0]     calibCnt_q, calibCnt_d;
  logic            calibDone_q, calibDone_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [5:0]      bl_q, bl_d;
  logic [5:0]      beats_q, beats_d;
  logic [2:0]      error_q;
  logic            rdValid_q;
  logic [63:0]     ramRdata_q;

  logic [CMD_ENTRY_W-1:0] cmdHeadRaw;
  cmdEntry_t       cmdHead;
  logic [2:0]      cmdCount;
  logic            cmdPop, cmdOver, cmdUnder;
  logic [WR_ENTRY_W-1:0] wrHead;
  logic            wrPop, wrOver, wrUnder;
  logic            rdOver, rdUnder;
  logic            ramWe, ramRe;

  sync_fifo #(.WIDTH(CMD_ENTRY_W), .DEPTH(CMD_FIFO_DEPTH)) cmdFifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (cmd_en_i),
    .data_i      ({6'b0, cmd_instr_i, cmd_bl_i, cmd_byte_addr_i}),
    .pop_i       (cmdPop),
    .data_o      (cmdHeadRaw),
    .count_o     (cmdCount),
    .full_o      (cmd_full_o),
    .empty_o     (cmd_empty_o),
    .overflow_o  (cmdOver),
    .underflow_o (cmdUnder)
  );

  sync_fifo #(.WIDTH(WR_ENTRY_W), .DEPTH(DATA_FIFO_DEPTH)) wrFifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (wr_en_i),
    .data_i      ({wr_mask_i, wr_data_i}),
    .pop_i       (wrPop),
    .data_o      (wrHead),
    .count_o     (wr_count_o),
    .full_o      (wr_full_o),
    .empty_o     (wr_empty_o),
    .overflow_o  (wrOver),
    .underflow_o (wrUnder)
  );

  sync_fifo #(.WIDTH(RD_ENTRY_W), .DEPTH(DATA_FIFO_DEPTH)) rdFifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (rdValid_q),
    .data_i      (ramRdata_q),
    .pop_i       (rd_en_i),
    .data_o      (rd_data_o),
    .count_o     (rd_count_o),
    .full_o      (rd_full_o),
    .empty_o     (rd_empty_o),
    .overflow_o  (rdOver),
    .underflow_o (rdUnder)
  );

  assign cmdHead      = cmdEntry_t'(cmdHeadRaw);
  assign calib_done_o = calibDone_q;
  assign error_o      = error_q;

  logic unusedBits;
  assign unusedBits = ^{cmdHead.rsvd, cmdHead.byteAddr, cmdCount, cmdUnder, wrUnder, rdOver};

`ifdef MCB_RESP_REFRESH_EN
  logic [15:0] refCnt_q;
  logic        refPending_q;
  logic [2:0]  stallCnt_q, stallCnt_d;
  logic        refClear;

  // A new refresh request wins over a clear landing in the same cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      refCnt_q     <= '0;
      refPending_q <= 1'b0;
      stallCnt_q   <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      if (refCnt_q == 16'(REFRESH_PERIOD - 1)) begin
        refCnt_q     <= '0;
        refPending_q <= 1'b1;
      end else begin
        refCnt_q <= refCnt_q + 1'b1;
        if (refClear) refPending_q <= 1'b0;
      end
    end
  end
`else
  localparam int unusedRefreshCfg = REFRESH_PERIOD + REFRESH_STALL;
`endif

  // The first word of each burst is moved in the WAIT state on the cycle
  // its condition is met, so beats_q counts the words still outstanding.
  always_comb begin
    state_d     = state_q;
    calibCnt_d  = calibCnt_q;
    calibDone_d = calibDone_q;
    addr_d      = addr_q;
    bl_d        = bl_q;
    beats_d     = beats_q;
    cmdPop      = 1'b0;
    wrPop       = 1'b0;
    ramWe       = 1'b0;
    ramRe       = 1'b0;
`ifdef MCB_RESP_REFRESH_EN
    stallCnt_d  = stallCnt_q;
    refClear    = 1'b0;
`endif
    unique case (state_q)
      ST_CALIB: begin
        calibCnt_d = calibCnt_q + 1'b1;
        if (calibCnt_q == CALIB_LAST) begin
          state_d     = ST_IDLE;
          calibDone_d = 1'b1;
        end
      end
      ST_IDLE: begin
`ifdef MCB_RESP_REFRESH_EN
        if (refPending_q) begin
          state_d    = ST_REFRESH;
          stallCnt_d = '0;
        end else
`endif
        if (!cmd_empty_o) begin
          cmdPop = 1'b1;
          bl_d   = cmdHead.bl;
          addr_d = cmdHead.byteAddr[AW+2:3];
          if (isWriteCmd(cmdHead.instr))     state_d = ST_WR_WAIT;
          else if (isReadCmd(cmdHead.instr)) state_d = ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (wr_count_o > 7'(bl_q)) begin
          wrPop   = 1'b1;
          ramWe   = 1'b1;
          addr_d  = addr_q + 1'b1;
          beats_d = bl_q;
          state_d = (bl_q == '0) ? ST_IDLE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        wrPop   = 1'b1;
        ramWe   = 1'b1;
        addr_d  = addr_q + 1'b1;
        beats_d = beats_q - 1'b1;
        if (beats_q == 6'd1) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        // Whole burst must fit, so in-flight words can never overflow.
        if ((7'(DATA_FIFO_DEPTH) - rd_count_o) > 7'(bl_q)) begin
          ramRe   = 1'b1;
          addr_d  = addr_q + 1'b1;
          beats_d = bl_q;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // With no reads left, this cycle only carries the final push.
        if (beats_q != '0) begin
          ramRe   = 1'b1;
          addr_d  = addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef MCB_RESP_REFRESH_EN
      ST_REFRESH: begin
        stallCnt_d = stallCnt_q + 1'b1;
        if (stallCnt_q == 3'(REFRESH_STALL - 1)) begin
          state_d  = ST_IDLE;
          refClear = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_CALIB;
      calibCnt_q  <= '0;
      calibDone_q <= 1'b0;
      addr_q      <= '0;
      bl_q        <= '0;
      beats_q     <= '0;
      error_q     <= '0;
      rdValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      calibCnt_q  <= calibCnt_d;
      calibDone_q <= calibDone_d;
      addr_q      <= addr_d;
      bl_q        <= bl_d;
      beats_q     <= beats_d;
      error_q     <= error_q | {rdUnder, wrOver, cmdOver};
      rdValid_q   <= ramRe;
    end
  end

  // Backing store; contents intentionally survive reset.
  logic [63:0] ram [2**AW];

  always_ff @(posedge clk_i) begin
    if (ramWe) begin
      for (int b = 0; b < 8; b++) begin
        if (!wrHead[64+b]) ram[addr_q][b*8 +: 8] <= wrHead[b*8 +: 8];
      end
    end
    if (ramRe) ramRdata_q <= ram[addr_q];
  end

endmodule

// File: tb/tb_mcb_port_responder.sv
// tb_mcb_port_responder
// Directed bench for mcb_port_responder with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mcb_port_responder;

  localparam int AW = 10;
  localparam logic [2:0] CMD_WRITE    = 3'b000;
  localparam logic [2:0] CMD_READ     = 3'b001;
  localparam logic [2:0] CMD_WRITE_AP = 3'b010;
  localparam logic [2:0] CMD_READ_AP  = 3'b011;
  localparam logic [2:0] CMD_REFRESH  = 3'b100;
  localparam logic [2:0] CMD_BOGUS    = 3'b111;
  localparam logic [29:0] TOP_ADDR    = 30'((2**AW - 2) * 8);

  logic        clock = 1'b0;
  logic        resetN;
  logic        calibDone;
  logic        cmdEn;
  logic [2:0]  cmdInstr;
  logic [5:0]  cmdBl;
  logic [29:0] cmdByteAddr;
  logic        cmdFull, cmdEmpty;
  logic        wrEn;
  logic [63:0] wrData;
  logic [7:0]  wrMask;
  logic        wrFull, wrEmpty;
  logic [6:0]  wrCount;
  logic        rdEn;
  logic [63:0] rdData;
  logic        rdFull, rdEmpty;
  logic [6:0]  rdCount;
  logic [2:0]  errorBits;

  int testCount = 0;
  int failCount = 0;

  always #5 clock = ~clock;

  mcb_port_responder dut (
    .clk_i           (clock),
    .reset_n_i       (resetN),
    .calib_done_o    (calibDone),
    .cmd_en_i        (cmdEn),
    .cmd_instr_i     (cmdInstr),
    .cmd_bl_i        (cmdBl),
    .cmd_byte_addr_i (cmdByteAddr),
    .cmd_full_o      (cmdFull),
    .cmd_empty_o     (cmdEmpty),
    .wr_en_i         (wrEn),
    .wr_data_i       (wrData),
    .wr_mask_i       (wrMask),
    .wr_full_o       (wrFull),
    .wr_empty_o      (wrEmpty),
    .wr_count_o      (wrCount),
    .rd_en_i         (rdEn),
    .rd_data_o       (rdData),
    .rd_full_o       (rdFull),
    .rd_empty_o      (rdEmpty),
    .rd_count_o      (rdCount),
    .error_o         (errorBits)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] byteAddr);
    cmdEn       = 1'b1;
    cmdInstr    = instr;
    cmdBl       = bl;
    cmdByteAddr = byteAddr;
    @(negedge clock);
    cmdEn = 1'b0;
  endtask

  task automatic pushWord(input logic [63:0] data, input logic [7:0] mask);
    wrEn   = 1'b1;
    wrData = data;
    wrMask = mask;
    @(negedge clock);
    wrEn = 1'b0;
  endtask

  task automatic popAndCheck(input string tag, input logic [63:0] expected);
    checkOutput(tag, rdData, expected);
    rdEn = 1'b1;
    @(negedge clock);
    rdEn = 1'b0;
  endtask

  task automatic popDiscard(input int n);
    rdEn = 1'b1;
    repeat (n) @(negedge clock);
    rdEn = 1'b0;
  endtask

  task automatic checkResetState(input string phase);
    checkOutput({phase, "/calib_done"}, calibDone, 0);
    checkOutput({phase, "/cmd_empty"},  cmdEmpty,  1);
    checkOutput({phase, "/cmd_full"},   cmdFull,   0);
    checkOutput({phase, "/wr_empty"},   wrEmpty,   1);
    checkOutput({phase, "/wr_full"},    wrFull,    0);
    checkOutput({phase, "/wr_count"},   wrCount,   0);
    checkOutput({phase, "/rd_empty"},   rdEmpty,   1);
    checkOutput({phase, "/rd_full"},    rdFull,    0);
    checkOutput({phase, "/rd_count"},   rdCount,   0);
    checkOutput({phase, "/rd_data"},    rdData,    0);
    checkOutput({phase, "/error"},      errorBits, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, %0d tests run so far", testCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN      = 1'b0;
    cmdEn       = 1'b0;
    cmdInstr    = '0;
    cmdBl       = '0;
    cmdByteAddr = '0;
    wrEn        = 1'b0;
    wrData      = '0;
    wrMask      = '0;
    rdEn        = 1'b0;

    // Reset values, then calibration rises on the 16th edge after release.
    tick(3);
    checkResetState("reset");
    resetN = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      checkOutput($sformatf("calib_edge%0d", i), calibDone, (i == 16));
    end

    // Six-word write then read-back at byte address 16.
    for (int i = 0; i < 6; i++) pushWord(64'd5, 8'h00);
    checkOutput("t2_wr_count", wrCount, 6);
    applyStimulus(CMD_WRITE, 6'd5, 30'd16);
    tick(10);
    checkOutput("t2_wr_drained", wrEmpty, 1);
    applyStimulus(CMD_READ, 6'd5, 30'd16);
    tick(2);
    checkOutput("t2_rd_empty_e2", rdEmpty, 1);
    tick(1);
    checkOutput("t2_rd_empty_e3", rdEmpty, 0);
    tick(6);
    checkOutput("t2_rd_count", rdCount, 6);
    for (int i = 0; i < 6; i++) popAndCheck($sformatf("t2_data%0d", i), 64'd5);
    checkOutput("t2_rd_empty_end", rdEmpty, 1);
    checkOutput("t2_error", errorBits, 0);

    // Byte mask; refresh and unknown commands must be dropped untouched.
    pushWord(64'h1111_1111_1111_1111, 8'h00);
    applyStimulus(CMD_REFRESH, 6'd0, 30'd8);
    applyStimulus(CMD_BOGUS, 6'd0, 30'd8);
    applyStimulus(CMD_WRITE_AP, 6'd0, 30'd0);
    tick(8);
    pushWord(64'hAAAA_AAAA_AAAA_AAAA, 8'hF0);
    applyStimulus(CMD_WRITE, 6'd0, 30'd0);
    tick(6);
    applyStimulus(CMD_READ_AP, 6'd0, 30'd0);
    tick(5);
    checkOutput("t3_rd_count", rdCount, 1);
    popAndCheck("t3_masked", 64'h1111_1111_AAAA_AAAA);

    // Wrap at the top of memory and address aliasing above AW+2.
    for (int i = 0; i < 4; i++) pushWord(64'hC0DE_0000_0000_0001 + 64'(i), 8'h00);
    applyStimulus(CMD_WRITE, 6'd3, TOP_ADDR);
    tick(8);
    applyStimulus(CMD_READ, 6'd1, 30'd0);
    tick(6);
    popAndCheck("t4_word0", 64'hC0DE_0000_0000_0003);
    popAndCheck("t4_word1", 64'hC0DE_0000_0000_0004);
    applyStimulus(CMD_READ, 6'd3, TOP_ADDR | 30'h0010_0000);
    tick(8);
    for (int i = 0; i < 4; i++)
      popAndCheck($sformatf("t4_alias%0d", i), 64'hC0DE_0000_0000_0001 + 64'(i));

    // Read waits for room: 60 queued, an 8-word burst needs 4 pops first.
    for (int i = 0; i < 8; i++) pushWord(64'h5000 + 64'(i), 8'h00);
    applyStimulus(CMD_WRITE, 6'd7, 30'd800);
    tick(12);
    applyStimulus(CMD_READ, 6'd59, 30'd0);
    tick(65);
    checkOutput("t5_fill", rdCount, 60);
    applyStimulus(CMD_READ, 6'd7, 30'd800);
    tick(10);
    checkOutput("t5_stall60", rdCount, 60);
    popDiscard(3);
    tick(10);
    checkOutput("t5_stall57", rdCount, 57);
    popDiscard(1);
    tick(15);
    checkOutput("t5_count", rdCount, 64);
    checkOutput("t5_rd_full", rdFull, 1);
    checkOutput("t5_error", errorBits, 0);
    popDiscard(56);
    for (int i = 0; i < 8; i++) popAndCheck($sformatf("t5_data%0d", i), 64'h5000 + 64'(i));
    checkOutput("t5_rd_empty", rdEmpty, 1);

    // Pre-calibration queueing, sticky errors, asynchronous mid-burst reset.
    resetN = 1'b0;
    tick(2);
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(CMD_READ, 6'd63, 30'd0);
      checkOutput($sformatf("t6_cmd_full%0d", i), cmdFull, (i >= 3));
    end
    checkOutput("t6_err_cmd", errorBits, 3'b001);
    rdEn = 1'b1;
    tick(1);
    rdEn = 1'b0;
    checkOutput("t6_err_rd", errorBits, 3'b101);
    for (int i = 0; i < 65; i++) pushWord(64'(i), 8'h00);
    checkOutput("t6_wr_full", wrFull, 1);
    checkOutput("t6_wr_count", wrCount, 64);
    checkOutput("t6_err_wr", errorBits, 3'b111);
    checkOutput("t6_calib", calibDone, 1);
    checkOutput("t6_burst_active", rdEmpty, 0);
    #2 resetN = 1'b0;
    #1 checkResetState("async");
    tick(1);
    resetN = 1'b1;
    tick(40);
    checkOutput("t6_recal", calibDone, 1);
    checkOutput("t6_cmd_flushed", cmdEmpty, 1);
    checkOutput("t6_no_data", rdEmpty, 1);
    checkOutput("t6_error_clear", errorBits, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mcb_port_responder.md
# mcb_port_responder

Synthesizable stand-in for one 64-bit Spartan-6 MCB user port (cmd / write-data / read-data FIFOs), backed by on-chip block RAM instead of DDR2. It answers the same command/FIFO protocol that our DDR test and streaming initiators drive, so those initiators can be brought up in simulation and on boards without the memory controller. It sits where `ddr_interface` normally sits, on the `c3_clk0` domain of the initiator.

## Interface
- `AW`, 10: log2 of memory depth in 64-bit words (default 1024 words = 8 KB).
- `CALIB_CYCLES`, 16: cycles after reset before `calib_done` rises.
- `REFRESH_PERIOD`, 780: cycles between injected refresh stalls (only with `MCB_RESP_REFRESH_EN`).
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `calib_done`  out  1  high once emulated calibration completes.
- `cmd_en`  in  1  push command when high and `cmd_full` low.
- `cmd_instr`  in  3  000 write, 001 read, 010 write+AP, 011 read+AP, 100 refresh; others ignored.
- `cmd_bl`  in  6  burst length minus 1 (0 → 1 word, 63 → 64 words).
- `cmd_byte_addr`  in  30  byte address; bits [2:0] ignored.
- `cmd_full` / `cmd_empty`  out  1 each  command FIFO status (depth 4).
- `wr_en`  in  1  push `wr_data`/`wr_mask` into write FIFO.
- `wr_data`  in  64  write word.
- `wr_mask`  in  8  per-byte mask; 1 = byte not written.
- `wr_full` / `wr_empty`  out  1 each  write FIFO status (depth 64).
- `wr_count`  out  7  write FIFO occupancy 0..64.
- `rd_en`  in  1  pop read FIFO.
- `rd_data`  out  64  head of read FIFO (first-word fall-through).
- `rd_full` / `rd_empty`  out  1 each  read FIFO status (depth 64).
- `rd_count`  out  7  read FIFO occupancy 0..64.
- `error`  out  3  sticky: [0] cmd push while full, [1] wr push while full, [2] rd pop while empty.

## Operation
- Reset (`reset_n` low, async): FSM → CALIB, calib counter 0, all FIFOs emptied, `calib_done`=0, `error`=0, `cmd_full`=`wr_full`=`rd_full`=0, `cmd_empty`=`wr_empty`=`rd_empty`=1, counts 0, `rd_data`=0. RAM contents not cleared. Reset mid-burst aborts the burst; partially written words remain.
- FSM states: CALIB → IDLE after `CALIB_CYCLES` cycles; `calib_done` set on entry to IDLE and held until reset.
- IDLE: if command FIFO non-empty, pop head; write-type → WR_WAIT, read-type → RD_WAIT, refresh/unknown → IDLE (discarded).
- WR_WAIT: stays until `wr_count` ≥ `cmd_bl`+1, then WRITE.
- WRITE: one word per cycle popped from write FIFO into RAM, byte enables = ~`wr_mask`; after `cmd_bl`+1 words → IDLE.
- RD_WAIT: stays until free space (64 − `rd_count`) ≥ `cmd_bl`+1; space is reserved at exit so the burst never overflows.
- READ: one RAM read per cycle; data pushed to read FIFO one cycle later (RAM latency 1); after final push → IDLE.
- Word address = `cmd_byte_addr`[AW+2:3]; incremented modulo 2^AW per word (wrap at top of memory). Address bits above AW+2 ignored (aliasing).
- Commands accepted before `calib_done` are queued and executed after calibration.
- Push/pop same cycle on any FIFO: occupancy unchanged, both succeed (a push into a full FIFO is dropped even with a simultaneous pop; sets error bit).
- `rd_en` while empty: no effect on FIFO, sets `error`[2].

## Timing
- Command sampled at edge E0 is popped at E1 (FSM idle, FIFO was empty).
- Write: with all words already in write FIFO, first RAM write at E2, last at E2+`cmd_bl`.
- Read: with space available, RAM read at E2, first push at E3; `rd_empty` low after E3; one new word per cycle thereafter.
- Back-to-back commands: one idle cycle between bursts (IDLE pop cycle).
- Status outputs are registered and reflect the state after each edge.

## Configuration
- `MCB_RESP_REFRESH_EN` defined: free-running counter; every `REFRESH_PERIOD` cycles a pending flag is set; the FSM enters REFRESH from IDLE (before popping) for 8 cycles, then clears the flag. Bursts are never interrupted.
- Undefined: no refresh counter or REFRESH state; command latency strictly as in Timing.

## Structure
- Package `mcb_pkg`: instruction encodings, FIFO depths (4, 64), FSM state enum, refresh stall length (8).
- Sub-module `sync_fifo` (parameterized width/depth, FWFT, count/full/empty outputs), instantiated for cmd (45-bit entries), write (72-bit entries) and read (64-bit entries) FIFOs. RAM inferred in the top level with byte-write enables.

## Test plan
- Reset then idle: `calib_done` rises exactly 16 cycles after `reset_n` release; all status at reset values.
- Push 6 words of 5, write bl=5 at addr 16, then read bl=5 at addr 16 → six reads of 64'd5, `rd_empty` low 3 cycles after read cmd, `error`=0.
- Write word at addr 0 with `wr_mask`=8'hF0 over prior 64'h1111…1111 using data 64'hAAAA…AAAA → readback 64'h11111111_AAAAAAAA.
- Write bl=3 at byte addr (2^AW−2)·8 → words land at AW-indices 1022, 1023, 0, 1; readback from addr 0 returns words 3 and 4.
- Fill read FIFO to 60 with rd_en held low, issue read bl=7 → FSM stays RD_WAIT until 4 words popped, then delivers all 8; `rd_full` never set by overflow, `error`=0.
- Push 5 commands back-to-back before calibration → `cmd_full` after 4th, `error`[0]=1; `rd_en` on empty → `error`[2]=1; assert `reset_n` mid-burst → all outputs return to reset values asynchronously.
